// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the writable instruction memory
//
// Receives frames of SYNC, LEN, 2*N data bytes (high byte first per word), CHK,
// writes each 16-bit word to consecutive instruction memory addresses from 0,
// and holds the processor in reset until a frame's checksum verifies.
//
// Ports:
//   clk         system clock, all state updates on rising edge
//   reset       synchronous, active-high reset
//   in_valid    byte available on in_data
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle (low in WR and during reset)
//   imem_we     instruction memory write strobe, one-cycle pulse
//   imem_addr   registered write address
//   imem_wdata  registered write word
//   cpu_reset   reset to PC / register file, high while not loaded
//   done        last frame loaded and verified
//   err         last frame failed checksum
module imem_loader #(
    parameter int         ADDR_W = 8,
    parameter int         DATA_W = 16,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [8:0]        remaining;   // one bit wider than LEN so LEN = 0 can mean 256
    logic [7:0]        checksum;
    logic [7:0]        hi_byte;
    logic              accept;

    assign in_ready = !reset && (state != S_WR);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && in_data == SYNC) state_nxt = S_LEN;
            S_LEN:   if (accept) state_nxt = S_HI;
            S_HI:    if (accept) state_nxt = S_LO;
            S_LO:    if (accept) state_nxt = S_WR;
            // remaining still counts the word just written; it drops on leaving WR
            S_WR:    state_nxt = (remaining > 9'd1) ? S_HI : S_CHK;
            S_CHK:   if (accept) state_nxt = (in_data == checksum) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:   if (accept && in_data == SYNC) state_nxt = S_LEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            addr_cnt   <= '0;
            remaining  <= '0;
            checksum   <= '0;
            hi_byte    <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN: if (accept) begin
                    remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    addr_cnt  <= '0;
                    checksum  <= '0;
                    cpu_reset <= 1'b1;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
                S_HI: if (accept) begin
                    hi_byte  <= in_data;
                    checksum <= checksum + in_data;
                end
                S_LO: if (accept) begin
                    // registered so the strobe, address and word all appear during WR
                    checksum   <= checksum + in_data;
                    imem_we    <= 1'b1;
                    imem_addr  <= addr_cnt;
                    imem_wdata <= {hi_byte, in_data};
                end
                S_WR: begin
                    addr_cnt  <= addr_cnt + 1'b1;
                    remaining <= remaining - 9'd1;
                end
                S_CHK: if (accept) begin
                    if (in_data == checksum) begin
                        done      <= 1'b1;
                        err       <= 1'b0;
                        cpu_reset <= 1'b0;
                    end else begin
                        done      <= 1'b0;
                        err       <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                end
                // a new frame puts the core back in reset right away; flags clear on LEN
                S_DONE,
                S_ERR: if (accept && in_data == SYNC) cpu_reset <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] frame_words[$];
    logic [7:0]  garbage[$];
    bit          gaps_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every write the DUT makes must match the next one the model predicted.
    always @(negedge clk) begin
        if (reset === 1'b0 && imem_we === 1'b1) begin
            check("wr_ready_low", {31'd0, in_ready}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", {24'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                check("wr_addr", {24'd0, imem_addr}, {24'd0, exp_addr_q.pop_front()});
                check("wr_data", {16'd0, imem_wdata}, {16'd0, exp_data_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", guard, (guard < 8) ? guard : 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Model: word i lands at address i mod 256; verdict is the byte sum versus CHK.
    task automatic send_frame(input bit corrupt);
        int   n = frame_words.size();
        int   sum = 0;
        logic [7:0] chk;
        for (int i = 0; i < n; i++) begin
            sum += frame_words[i][15:8] + frame_words[i][7:0];
            exp_addr_q.push_back(8'(i % 256));
            exp_data_q.push_back(frame_words[i]);
        end
        chk = 8'(sum % 256);
        if (corrupt) chk = chk + 8'd1;
        foreach (garbage[i]) send_byte(garbage[i]);
        garbage.delete();
        send_byte(8'hA5);
        @(negedge clk);
        check("sync_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'(n % 256));
        for (int i = 0; i < n; i++) begin
            send_byte(frame_words[i][15:8]);
            if (i == 0) begin
                check("load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
                check("load_done", {31'd0, done}, 32'd0);
            end
            send_byte(frame_words[i][7:0]);
        end
        send_byte(chk);
        @(negedge clk);
        check("frm_done", {31'd0, done}, {31'd0, !corrupt});
        check("frm_err", {31'd0, err}, {31'd0, corrupt});
        check("frm_cpu_reset", {31'd0, cpu_reset}, {31'd0, corrupt});
        check("frm_pending_wr", exp_addr_q.size(), 0);
        frame_words.delete();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();

        frame_words = '{16'h1234, 16'h5678};
        send_frame(1'b0);

        frame_words = '{16'h1234, 16'h5678};
        send_frame(1'b1);

        frame_words = '{16'h0000};
        send_frame(1'b0);

        garbage     = '{8'h00, 8'hFF, 8'h3C};
        frame_words = '{16'hABCD};
        send_frame(1'b0);

        for (int i = 0; i < 256; i++) frame_words.push_back(16'h0101);
        send_frame(1'b0);

        // reset after the high byte of the first word: nothing may be written
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        do_reset();
        repeat (4) @(negedge clk);
        check("midrst_pending_wr", exp_addr_q.size(), 0);
        frame_words = '{16'hBEEF, 16'h0042};
        send_frame(1'b0);

        gaps_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < 2; g++) garbage.push_back(8'($urandom_range(0, 8'hA4)));
            end
            send_frame($urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a framed byte stream and assembles 16-bit instructions.
- Writes each instruction into the writable instruction memory that the program counter reads from (8-bit address, 16-bit word).
- Holds the processor in reset while a load is in progress, and releases it only after a frame's checksum verifies.
- Sits between the host byte link and the instruction memory write port, next to the processor core.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit program counter).
- DATA_W, 16, instruction width; fixed at 2 bytes per word, high byte first.
- SYNC, 8'hA5, frame header byte.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte this cycle; a byte transfers when in_valid && in_ready
- imem_we  output  1  instruction memory write strobe, one-cycle pulse
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  DATA_W  write word
- cpu_reset  output  1  reset to PC/register file; high while not loaded
- done  output  1  last frame loaded and verified
- err  output  1  last frame failed checksum

Behaviour:
- Frame format: SYNC, LEN, then 2*N data bytes (hi, lo per word), then CHK.
  - N = LEN, except LEN = 0 means N = 256.
  - CHK = 8-bit modular sum of all 2*N data bytes; SYNC and LEN are not included.
- States: IDLE, LEN, HI, LO, WR, CHK, DONE, ERR. All transitions below occur on an accepted byte unless stated otherwise.
  - IDLE: SYNC goes to LEN. Any other byte is consumed and discarded.
  - LEN: latch count, clear addr counter and checksum, assert cpu_reset, clear done/err, go to HI.
  - HI: latch byte as word[15:8], add it to the checksum, go to LO.
  - LO: latch byte as word[7:0], add it to the checksum, go to WR.
  - WR: lasts exactly one cycle with in_ready = 0, imem_we = 1, imem_addr = addr counter, imem_wdata = word.
    - The next cycle increments the addr counter (wraps 255 to 0) and decrements the remaining count.
    - Go to HI if words remain, else CHK.
  - CHK: if byte equals the checksum, go to DONE (done = 1, cpu_reset = 0, err = 0). Otherwise go to ERR (err = 1, cpu_reset stays 1, done = 0).
  - DONE / ERR: SYNC starts a new frame, going to LEN and re-asserting cpu_reset on the cycle after the accept. Other bytes are discarded and outputs are held.
- in_ready = 1 in every state except WR, and is 0 while reset is asserted.
- imem_addr and imem_wdata are registered. They hold their last values outside WR, and writes occur only in WR.
- Reset (synchronous, any state, including mid-frame):
  - state = IDLE, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_reset = 1, done = 0, err = 0, internal counters cleared.
  - Memory contents already written are not rolled back.
- A mid-frame SYNC byte is treated as data; there is no resynchronisation except via reset or a checksum failure.
- in_valid low: the state holds indefinitely, and there is no timeout.
- The earliest cpu_reset deassertion is the cycle after the CHK byte is accepted.

Test Plan:
- Reset held 2 cycles -> cpu_reset = 1, done = 0, err = 0, imem_we = 0, in_ready = 0 during reset and 1 after.
- Frame A5 02 12 34 56 78 14, in_valid held high:
  - imem_we pulses twice, with addr 0 / data 0x1234, then addr 1 / data 0x5678.
  - in_ready is 0 in each WR cycle.
  - done = 1 and cpu_reset = 0 the cycle after byte 14 is accepted.
- Same frame with CHK = 15 -> both writes still occur; err = 1, done = 0, cpu_reset stays 1.
  - A following valid frame A5 01 00 00 00 clears err, sets done = 1, and writes addr 0 = 0x0000.
- Leading garbage 00 FF 3C then A5 01 AB CD 78 -> garbage is ignored, a single write addr 0 = 0xABCD, done = 1.
- LEN = 00 with 512 bytes of 0x01 and CHK = 0x00 (512 mod 256) -> 256 writes, addresses 0..255, each data 0x0101, done = 1.
- Reset asserted after the HI byte of word 1 -> returns to IDLE, cpu_reset = 1, no further writes; a new frame then loads correctly starting at addr 0.
